data_sram_resp: RTL and testbench

- Responder (slave) end of the CPU data-SRAM request interface.
- Memory-access stage issues requests; this block is the memory model the SoC/testbench ties to the CPU core.
- Accepts read/write requests with an addr_ok handshake, holds up to QDEPTH outstanding transactions, and returns in-order data_ok responses after a programmable latency.
- Backs a word-organised RAM array with byte write strobes.

---
 rtl/data_sram_resp_pkg.sv | 37 +++
 rtl/dsram_resp_queue.sv | 84 ++++++++
 rtl/data_sram_resp.sv | 107 ++++++++++
 tb/tb_data_sram_resp.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_resp_pkg
// Description : Shared types and constants for the data-SRAM responder.
//               DSRAM_RAND_DELAY_EN widens the entry countdown so that
//               LATENCY+3 still fits.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sram_resp_pkg;

    localparam int DSRAM_WORD_W = 32;

`ifdef DSRAM_RAND_DELAY_EN
    // Randomised delay can reach LATENCY+3 = 10, which needs a fourth bit.
    localparam int DSRAM_CNT_W = 4;
`else
    localparam int DSRAM_CNT_W = 3;
`endif

    // Galois LFSR for x^8+x^6+x^5+x^4+1, right-shifting form.
    localparam logic [7:0] DSRAM_LFSR_SEED = 8'hA5;
    localparam logic [7:0] DSRAM_LFSR_TAPS = 8'hB8;

    // One outstanding transaction waiting for its data_ok.
    typedef struct packed {
        logic                    is_wr;
        logic [DSRAM_WORD_W-1:0] data;
        logic [DSRAM_CNT_W-1:0]  cnt;
    } dsram_entry_t;

    // Advance the LFSR by one step.
    function automatic logic [7:0] dsram_lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ DSRAM_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage : data_sram_resp_pkg
`default_nettype wire

// File: rtl/dsram_resp_queue.sv
`default_nettype none
// ============================================================================
// Module      : dsram_resp_queue
// Description : In-order circular buffer of outstanding responses. Every
//               valid entry counts down to zero independently; only the head
//               may retire, so a finished entry waits behind a slower head.
// Revision    : 1.0 - initial release
// ============================================================================
module dsram_resp_queue
    import data_sram_resp_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  dsram_entry_t                   push_entry_i,
    input  logic                           pop_i,
    output logic [$clog2(QDEPTH+1)-1:0]    count_o,
    output logic                           head_valid_o,
    output dsram_entry_t                   head_o
);

    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_QW = $clog2(QDEPTH + 1);

    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_QW-1:0] count_q;
    logic [CNT_QW-1:0] count_d;
    logic [QDEPTH-1:0] valid_q;
    dsram_entry_t      slots_q [QDEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Slot storage, per-entry countdown and head/tail pointer movement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (valid_q[i] && (slots_q[i].cnt != '0)) begin
                    slots_q[i].cnt <= slots_q[i].cnt - 1'b1;
                end
            end
            if (pop_i) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            // The tail slot is never valid when a push is allowed, so the
            // countdown above never touches it in the same cycle.
            if (push_i) begin
                slots_q[tail_q] <= push_entry_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q[head_q];
    assign head_o       = slots_q[head_q];

endmodule : dsram_resp_queue
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_resp
// Description : Responder end of the CPU data-SRAM interface. Word RAM with
//               byte strobes, addr_ok accept handshake, up to QDEPTH
//               outstanding transactions answered in order with data_ok
//               after LATENCY cycles.
//               Optional macro DSRAM_RAND_DELAY_EN adds 0..3 cycles of
//               LFSR-driven extra latency per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(QDEPTH + 1);

    logic [DSRAM_WORD_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]       w_idx;
    logic                    w_unused_addr;
    logic                    w_accept;
    logic [DSRAM_WORD_W-1:0] w_rd_word;
    logic [DSRAM_CNT_W-1:0]  w_init_cnt;
    logic [CW-1:0]           w_count;
    logic                    w_head_valid;
    dsram_entry_t            w_head;
    dsram_entry_t            w_push_entry;

    assign w_idx         = data_sram_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Capacity is judged on the registered count only; a retire in the same
    // cycle does not open a slot until the next edge.
    assign data_sram_addr_ok = (w_count < CW'(QDEPTH));
    assign w_accept          = data_sram_req & data_sram_addr_ok;

    // Read side samples the word before this edge's write lands; only one
    // request is accepted per cycle, so earlier writes are already visible.
    assign w_rd_word = mem_q[w_idx];

`ifdef DSRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    // Per-accept LFSR step; its low bits stretch that entry's latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= DSRAM_LFSR_SEED;
        end else if (w_accept) begin
            lfsr_q <= dsram_lfsr_next(lfsr_q);
        end
    end

    assign w_init_cnt = DSRAM_CNT_W'(LATENCY) + DSRAM_CNT_W'(lfsr_q[1:0]);
`else
    assign w_init_cnt = DSRAM_CNT_W'(LATENCY);
`endif

    assign w_push_entry.is_wr = data_sram_wr;
    assign w_push_entry.data  = data_sram_wr ? '0 : w_rd_word;
    assign w_push_entry.cnt   = w_init_cnt;

    // Byte-strobed RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    dsram_resp_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .push_i       (w_accept),
        .push_entry_i (w_push_entry),
        .pop_i        (data_sram_data_ok),
        .count_o      (w_count),
        .head_valid_o (w_head_valid),
        .head_o       (w_head)
    );

    assign data_sram_data_ok = w_head_valid && (w_head.cnt == '0);
    assign data_sram_rdata   = (data_sram_data_ok && !w_head.is_wr) ? w_head.data : '0;

endmodule : data_sram_resp
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_resp
// Description : Self-checking bench for data_sram_resp. Instance u_dut1
//               (LATENCY=1, QDEPTH=2) is scored against a word/byte memory
//               model with an in-order expected-response queue; instance
//               u_dut3 (LATENCY=3, QDEPTH=2) exercises the full-queue stall.
//               Honours DSRAM_RAND_DELAY_EN for the latency window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

    localparam int L1 = 1;
    localparam int L3 = 3;
`ifdef DSRAM_RAND_DELAY_EN
    localparam int RND = 3;
`else
    localparam int RND = 0;
`endif

    logic        clk;
    logic        resetn;
    int          cyc;
    int          checks;
    int          errors;

    logic        req1, wr1;
    logic [3:0]  strb1;
    logic [31:0] addr1, wdata1;
    logic        addr_ok1, data_ok1;
    logic [31:0] rdata1;

    logic        req3, wr3;
    logic [3:0]  strb3;
    logic [31:0] addr3, wdata3;
    logic        addr_ok3, data_ok3;
    logic [31:0] rdata3;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] last_rdata;
    logic [31:0] mmem   [1024];
    logic [3:0]  mknown [1024];

    data_sram_resp #(.ADDR_W(10), .LATENCY(L1), .QDEPTH(2)) u_dut1 (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req1),
        .data_sram_wr      (wr1),
        .data_sram_wstrb   (strb1),
        .data_sram_addr    (addr1),
        .data_sram_wdata   (wdata1),
        .data_sram_addr_ok (addr_ok1),
        .data_sram_data_ok (data_ok1),
        .data_sram_rdata   (rdata1)
    );

    data_sram_resp #(.ADDR_W(10), .LATENCY(L3), .QDEPTH(2)) u_dut3 (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req3),
        .data_sram_wr      (wr3),
        .data_sram_wstrb   (strb3),
        .data_sram_addr    (addr3),
        .data_sram_wdata   (wdata3),
        .data_sram_addr_ok (addr_ok3),
        .data_sram_data_ok (data_ok3),
        .data_sram_rdata   (rdata3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    // Reference memory update and expected-response creation at accept time.
    function automatic void model_accept(input logic wr, input logic [3:0] strb,
                                         input logic [31:0] addr, input logic [31:0] data,
                                         input int acc);
        int   idx;
        exp_t x;
        idx   = int'(addr[11:2]);
        x.acc = acc;
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mmem[idx][8*b +: 8] = data[8*b +: 8];
                    mknown[idx][b]      = 1'b1;
                end
            end
            x.data = 32'h0;
            x.mask = 32'hFFFF_FFFF;
        end else begin
            x.data = mmem[idx];
            for (int b = 0; b < 4; b++) begin
                x.mask[8*b +: 8] = {8{mknown[idx][b]}};
            end
        end
        exp_q.push_back(x);
    endfunction

    // Response monitor for u_dut1: order, data, latency window, idle rdata.
    always @(negedge clk) begin
        if (data_ok1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_data_ok cyc=%0d got data_ok=1 expected 0", cyc);
            end else begin
                e          = exp_q.pop_front();
                last_rdata = rdata1;
                if (((rdata1 ^ e.data) & e.mask) !== 32'h0) begin
                    errors++;
                    $display("FAIL resp_rdata cyc=%0d got %08h expected %08h (mask %08h)",
                             cyc, rdata1, e.data, e.mask);
                end
                checks++;
                if ((cyc - e.acc) < L1 || (cyc - e.acc) > L1 + RND) begin
                    errors++;
                    $display("FAIL resp_latency cyc=%0d got %0d expected %0d..%0d",
                             cyc, cyc - e.acc, L1, L1 + RND);
                end
            end
        end else begin
            checks++;
            if (rdata1 !== 32'h0) begin
                errors++;
                $display("FAIL idle_rdata cyc=%0d got %08h expected 00000000", cyc, rdata1);
            end
            if (exp_q.size() > 0 && (cyc - exp_q[0].acc) > L1 + RND) begin
                checks++;
                errors++;
                $display("FAIL resp_timeout cyc=%0d got no data_ok expected one by latency %0d",
                         cyc, L1 + RND);
                void'(exp_q.pop_front());
            end
        end
    end

    // Present a request on u_dut1 and hold it until accepted (req stays high).
    task automatic issue1(input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] data);
        int w;
        w      = 0;
        req1   = 1'b1;
        wr1    = wr;
        strb1  = strb;
        addr1  = addr;
        wdata1 = data;
        @(negedge clk);
        while (!addr_ok1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!addr_ok1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got addr_ok=0 expected 1 within 64 cycles");
            req1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_accept(wr, strb, addr, data, cyc);
    endtask

    task automatic idle1();
        req1   = 1'b0;
        wr1    = 1'b0;
        strb1  = 4'h0;
        wdata1 = 32'h0;
    endtask

    task automatic drain1();
        int w;
        w = 0;
        idle1();
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle1();
        addr1 = 32'h0;
        req3 = 1'b0; wr3 = 1'b0; strb3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (addr_ok1 !== 1'b1 || data_ok1 !== 1'b0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got addr_ok=%b data_ok=%b rdata=%08h expected 1 0 00000000",
                     addr_ok1, data_ok1, rdata1);
        end
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (addr_ok1 !== 1'b1 || data_ok1 !== 1'b0 || rdata1 !== 32'h0 ||
                addr_ok3 !== 1'b1 || data_ok3 !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d got addr_ok=%b data_ok=%b rdata=%08h expected 1 0 00000000",
                         i, addr_ok1, data_ok1, rdata1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        issue1(1'b1, 4'b1111, 32'h0000_0040, 32'h1122_3344);
        issue1(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        drain1();
        checks++;
        if (last_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL write_read got %08h expected 11223344", last_rdata);
        end
    endtask

    task automatic test_strobe();
        issue1(1'b1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD);
        issue1(1'b0, 4'b1111, 32'h0000_0040, 32'hFFFF_FFFF);
        drain1();
        checks++;
        if (last_rdata !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_merge got %08h expected 11BB33DD", last_rdata);
        end
        // A write with no strobes still answers but changes nothing.
        issue1(1'b1, 4'b0000, 32'h0000_0040, 32'h0000_0000);
        issue1(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        drain1();
        checks++;
        if (last_rdata !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL zero_strobe got %08h expected 11BB33DD", last_rdata);
        end
    endtask

    task automatic test_full_stall();
        int          a  [3];
        int          d  [3];
        logic [31:0] rd [3];
        logic [31:0] wv [3];
        wv[0] = 32'h0BAD_0001;
        wv[1] = 32'h0BAD_0002;
        wv[2] = 32'h0BAD_0003;
        for (int run = 0; run < 2; run++) begin
            fork
                begin
                    for (int i = 0; i < 3; i++) begin
                        int w;
                        w      = 0;
                        req3   = 1'b1;
                        wr3    = (run == 0);
                        strb3  = 4'hF;
                        addr3  = 32'h0000_0100 + 32'(i * 4);
                        wdata3 = wv[i];
                        @(negedge clk);
                        while (!addr_ok3 && w < 64) begin
                            @(negedge clk);
                            w++;
                        end
                        @(posedge clk);
                        #1;
                        a[i] = cyc;
                    end
                    req3 = 1'b0;
                end
                begin
                    for (int i = 0; i < 3; i++) begin
                        int w;
                        w = 0;
                        @(negedge clk);
                        while (!data_ok3 && w < 64) begin
                            @(negedge clk);
                            w++;
                        end
                        d[i]  = data_ok3 ? cyc : -1000;
                        rd[i] = rdata3;
                    end
                end
            join
            checks++;
            if (a[1] !== a[0] + 1) begin
                errors++;
                $display("FAIL stall_second_accept run %0d got cyc %0d expected %0d", run, a[1], a[0] + 1);
            end
            checks++;
            if (a[2] !== d[0] + 2) begin
                errors++;
                $display("FAIL stall_third_accept run %0d got cyc %0d expected %0d", run, a[2], d[0] + 2);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ((d[i] - a[i]) < L3 || (d[i] - a[i]) > L3 + RND) begin
                    errors++;
                    $display("FAIL stall_latency run %0d resp %0d got %0d expected %0d..%0d",
                             run, i, d[i] - a[i], L3, L3 + RND);
                end
                checks++;
                if (rd[i] !== ((run == 0) ? 32'h0 : wv[i])) begin
                    errors++;
                    $display("FAIL stall_rdata run %0d resp %0d got %08h expected %08h",
                             run, i, rd[i], (run == 0) ? 32'h0 : wv[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (d[i] <= d[i-1]) begin
                        errors++;
                        $display("FAIL stall_order run %0d resp %0d got cyc %0d expected > %0d",
                                 run, i, d[i], d[i-1]);
                    end
                end
            end
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midop();
        issue1(1'b1, 4'b1111, 32'h0000_0080, 32'hCAFE_F00D);
        drain1();
        issue1(1'b0, 4'b0000, 32'h0000_0080, 32'h0);
        issue1(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        resetn = 1'b0;
        exp_q.delete();
        idle1();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_ok1 !== 1'b0 || addr_ok1 !== 1'b1) begin
                errors++;
                $display("FAIL midop_in_reset got data_ok=%b addr_ok=%b expected 0 1", data_ok1, addr_ok1);
            end
        end
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        issue1(1'b0, 4'b0000, 32'h0000_0080, 32'h0);
        drain1();
        checks++;
        if (last_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL ram_survives_reset got %08h expected CAFEF00D", last_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [9:0]  idx;
        for (int n = 0; n < 100; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                idle1();
                repeat (gap) @(posedge clk);
                #1;
            end
            r   = $urandom;
            idx = 10'($urandom_range(0, 15));
            issue1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   {r[31:12], idx, r[1:0]}, $urandom);
        end
        drain1();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mmem[i]   = 32'h0;
            mknown[i] = 4'h0;
        end
        test_reset();
        test_write_read();
        test_strobe();
        test_full_stall();
        test_reset_midop();
        test_random();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_sram_resp
`default_nettype wire
